// File: rtl/dvs_event_drain_pkg.sv
// Shared definitions for the DVS event FIFO reader.
//   state_t             : drain FSM states (IDLE, SEND)
//   DVS_EVENT_WIDTH     : default bits per FIFO event word (shared with the FIFO)
//   DVS_OUT_WIDTH       : default bits per RAVENS ingress beat
package dvs_event_drain_pkg;

    localparam int DVS_EVENT_WIDTH = 16;
    localparam int DVS_OUT_WIDTH   = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/dvs_event_drain.sv
// Reader end of the DVS event FIFO. Pops one event word at a time and
// serializes it MSB-first into OUT_WIDTH-bit beats toward RAVENS.
//
// Ports:
//   clk, rst      : clock (rising edge), asynchronous active-high reset
//   enable        : permits new pops; an event in progress always completes
//   fifo_empty    : FIFO empty flag
//   fifo_data     : FIFO read data, valid in the cycle fifo_pop is high
//   fifo_pop      : combinational pop strobe, one cycle per event
//   out_data      : current beat (upper OUT_WIDTH bits of the shift register)
//   out_valid     : beat valid
//   out_last      : final beat of the event, qualified by out_valid
//   out_ready     : downstream accepts the beat
//   busy          : high while in SEND (exposes the FSM state)
//   event_count   : saturating count of fully transmitted events
//
// Handshake: a beat transfers in the cycle where out_valid && out_ready are
// both high; out_data/out_last hold stable while out_ready is low, and
// out_valid never drops once raised until the beat has transferred.
module dvs_event_drain
    import dvs_event_drain_pkg::*;
#(
    parameter int EVENT_WIDTH = DVS_EVENT_WIDTH,
    parameter int OUT_WIDTH   = DVS_OUT_WIDTH,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   fifo_empty,
    input  logic [EVENT_WIDTH-1:0] fifo_data,
    output logic                   fifo_pop,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic                   out_valid,
    output logic                   out_last,
    input  logic                   out_ready,
    output logic                   busy,
    output logic [CNT_WIDTH-1:0]   event_count
);

    localparam int BEATS = EVENT_WIDTH / OUT_WIDTH;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    if (EVENT_WIDTH % OUT_WIDTH != 0) begin : g_width_check
        $error("EVENT_WIDTH must be an integer multiple of OUT_WIDTH");
    end

    state_t                 state_q, state_d;
    logic [EVENT_WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]          beat_q, beat_d;
    logic [CNT_WIDTH-1:0]   count_q;
    logic                   count_inc;
    logic                   pop_ok;

    // rst gates the pop so the FIFO never loses a word while we are held in reset.
    assign pop_ok = enable && !fifo_empty && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            beat_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            beat_q  <= beat_d;
            if (count_inc && (count_q != {CNT_WIDTH{1'b1}})) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        beat_d    = beat_q;
        fifo_pop  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        busy      = 1'b0;
        count_inc = 1'b0;

        case (state_q)
            IDLE: begin
                if (pop_ok) begin
                    fifo_pop = 1'b1;
                    shreg_d  = fifo_data;
                    beat_d   = '0;
                    state_d  = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_data  = shreg_q[EVENT_WIDTH-1 -: OUT_WIDTH];
                out_last  = (beat_q == BW'(BEATS - 1));
                if (out_ready) begin
                    if (!out_last) begin
                        shreg_d = shreg_q << OUT_WIDTH;
                        beat_d  = beat_q + 1'b1;
                    end else begin
                        count_inc = 1'b1;
                        // Chain straight into the next event to avoid an idle bubble.
                        if (pop_ok) begin
                            fifo_pop = 1'b1;
                            shreg_d  = fifo_data;
                            beat_d   = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign event_count = count_q;

endmodule

// File: doc/dvs_event_drain.md
Name: dvs_event_drain

Overview:
- Reader end of the DVS event FIFO: pops buffered event words and serializes each one, MSB-first, into OUT_WIDTH-bit beats on a valid/ready stream toward the RAVENS input port.
- Marks the final beat of each event with out_last and keeps a saturating count of fully transmitted events for debug readout.
- Sits between the event FIFO read side (pop/empty/data) and the RAVENS ingress.

Parameters:
- EVENT_WIDTH, 16, bits per FIFO event word; must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, 8, bits per output beat.
- CNT_WIDTH, 16, width of the sent-event counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  permits new pops; does not abort an event already in progress.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  EVENT_WIDTH  FIFO read data; valid in the same cycle fifo_pop is high.
- fifo_pop  output  1  combinational pop strobe, one cycle per event.
- out_data  output  OUT_WIDTH  current beat.
- out_valid  output  1  beat valid.
- out_last  output  1  final beat of the event; qualified by out_valid.
- out_ready  input  1  downstream accepts the beat.
- busy  output  1  high while in SEND.
- event_count  output  CNT_WIDTH  number of events fully sent; saturates.

Behaviour:
- BEATS = EVENT_WIDTH / OUT_WIDTH, a localparam. Elaboration error if EVENT_WIDTH % OUT_WIDTH != 0.
- Reset (async, rst=1): state=IDLE; shift register=0; beat_cnt=0; event_count=0. Outputs: out_valid=0, out_last=0, out_data=0, busy=0, fifo_pop=0.
- State IDLE:
  - fifo_pop = enable && !fifo_empty.
  - On pop: capture fifo_data into shift register, beat_cnt<=0, go to SEND.
- State SEND:
  - out_valid=1, busy=1.
  - out_data = shift register's upper OUT_WIDTH bits.
  - out_last = (beat_cnt == BEATS-1).
- Handshake: a beat transfers on the cycle where out_valid && out_ready. out_data and out_last hold stable while out_ready=0.
- Non-last transfer: shift register shifts left by OUT_WIDTH; beat_cnt++.
- Last transfer:
  - event_count++, saturating at all-ones.
  - If enable && !fifo_empty in that same cycle: fifo_pop=1, load the new word, beat_cnt<=0, stay in SEND (no bubble).
  - Otherwise go to IDLE.
- fifo_pop is never asserted when fifo_empty=1, and never asserted in SEND except on a last-beat transfer.
- Latency: FIFO non-empty while IDLE at cycle N -> pop in N -> first beat valid at N+1.
- Throughput: with out_ready held high, exactly BEATS cycles per event, back-to-back.
- enable drop mid-event: current event completes, then return to IDLE. No pop while enable=0.
- BEATS=1: every beat is last; one pop per accepted beat.
- Reset mid-event: partial event discarded, no beat after reset; the FIFO shares the reset, so nothing is accounted.

Decomposition:
- Shared package: state typedef (IDLE, SEND) and the default EVENT_WIDTH / OUT_WIDTH constants used by the FIFO and this block.
- Single module. No sub-module is warranted; the shift/beat counter stays inline.

Test Plan:
- Defaults; push 0xA55A; out_ready=1, enable=1 -> pop in cycle N; beats 0xA5 (last=0), then 0x5A (last=1) in N+1 and N+2; event_count=1; then IDLE with busy=0.
- Push 0x1234 and 0xBEEF; ready=1 -> beats 12, 34, BE, EF on 4 consecutive cycles; second pop coincides with the 0x34 transfer; event_count=2.
- 0xC3E1 with out_ready low for 3 cycles at beat 0 -> out_data holds 0xC3, out_valid stays high; no extra pop; then 0xE1 follows.
- enable=0 with FIFO holding 2 words -> fifo_pop stays 0. Drop enable after the first beat of an event -> that event finishes; next pop only after enable=1.
- Assert rst during the second beat -> all outputs 0 on the next sample; event_count=0; no stale beat after release.
- CNT_WIDTH=2; send 5 events -> event_count reads 1, 2, 3, 3, 3.
